// File: rtl/fetch_ctrl.sv
// Program counter and run control for the instruction ROM: start handshake,
// relative branching, halt on Ack, done flag and a saturating run-cycle counter.
//
// state | meaning
// IDLE  | after reset, waiting for Start; PC and cycle count hold
// RUN   | fetching; PC advances or branches every cycle, cycle count increments
// HALT  | halt instruction seen; PC points at it, Done high until next Start
module fetch_ctrl #(
  parameter int PW     = 10,
  parameter int W      = 8,
  parameter int START0 = 0,
  parameter int START1 = 256,
  parameter int START2 = 512,
  parameter int CW     = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    ProgSel,
  input  logic          BranchUp,
  input  logic          BranchDown,
  input  logic [W-1:0]  PCTarget,
  input  logic          Ack,
  output logic [PW-1:0] ProgCtr,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCount
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam int XW = (PW > W) ? PW : W;
  localparam logic [PW-1:0] S0 = PW'(START0);
  localparam logic [PW-1:0] S1 = PW'(START1);
  localparam logic [PW-1:0] S2 = PW'(START2);

  state_t        state, state_nxt;
  logic [PW-1:0] pc_nxt, start_pc, pc_fwd, pc_back;
  logic [CW-1:0] cnt_nxt;
  logic [XW-1:0] pc_x, tgt_x, sum_x, diff_x;

  // Branch math done at the wider width; truncation gives modulo-2^PW wrap.
  assign pc_x    = XW'(ProgCtr);
  assign tgt_x   = XW'(PCTarget);
  assign sum_x   = pc_x + tgt_x;
  assign diff_x  = pc_x - tgt_x;
  assign pc_fwd  = sum_x[PW-1:0];
  assign pc_back = diff_x[PW-1:0];

  always_comb begin
    case (ProgSel)
      2'd1:    start_pc = S1;
      2'd2:    start_pc = S2;
      default: start_pc = S0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = ProgCtr;
    cnt_nxt   = CycleCount;
    case (state)
      IDLE, HALT: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = start_pc;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (CycleCount != {CW{1'b1}}) cnt_nxt = CycleCount + CW'(1);
        if (Ack)             state_nxt = HALT;
        else if (BranchDown) pc_nxt    = pc_fwd;
        else if (BranchUp)   pc_nxt    = pc_back;
        else                 pc_nxt    = ProgCtr + PW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      CycleCount <= '0;
    end else begin
      state      <= state_nxt;
      ProgCtr    <= pc_nxt;
      CycleCount <= cnt_nxt;
    end
  end

  assign Running = (state == RUN);
  assign Done    = (state == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed test-plan sequences then random traffic, all
// checked against an arithmetic reference model (plus a CW=4 instance for saturation).
module tb_fetch_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Start, BranchUp, BranchDown, Ack;
  logic [1:0] ProgSel;
  logic [7:0] PCTarget;
  logic [9:0] ProgCtr, ProgCtr4;
  logic       Running, Done, Running4, Done4;
  logic [15:0] CycleCount;
  logic [3:0]  CycleCount4;

  int checks = 0;
  int errors = 0;

  // Model: run phase as a name, counts as plain integers.
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_HALT = 2;
  int m_phase, m_pc, m_cnt16, m_cnt4;

  fetch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
    .BranchUp(BranchUp), .BranchDown(BranchDown), .PCTarget(PCTarget), .Ack(Ack),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .CycleCount(CycleCount)
  );

  fetch_ctrl #(.CW(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
    .BranchUp(BranchUp), .BranchDown(BranchDown), .PCTarget(PCTarget), .Ack(Ack),
    .ProgCtr(ProgCtr4), .Running(Running4), .Done(Done4), .CycleCount(CycleCount4)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int start_addr(input int sel);
    case (sel)
      1: return 256;
      2: return 512;
      default: return 0;
    endcase
  endfunction

  function automatic void model_step();
    if (Reset) begin
      m_phase = PH_IDLE; m_pc = 0; m_cnt16 = 0; m_cnt4 = 0;
    end else if (m_phase == PH_RUN) begin
      m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
      m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
      if (Ack)             m_phase = PH_HALT;
      else if (BranchDown) m_pc = (m_pc + int'(PCTarget)) % 1024;
      else if (BranchUp)   m_pc = (m_pc - int'(PCTarget) + 1024) % 1024;
      else                 m_pc = (m_pc + 1) % 1024;
    end else if (Start) begin
      m_phase = PH_RUN; m_pc = start_addr(int'(ProgSel)); m_cnt16 = 0; m_cnt4 = 0;
    end
  endfunction

  task automatic drive(input bit st, input int sel, input bit bu, input bit bd,
                       input int tgt, input bit ak);
    Start = st; ProgSel = 2'(sel); BranchUp = bu; BranchDown = bd;
    PCTarget = 8'(tgt); Ack = ak;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge Clk);
    #1;
    check({tag, ".pc"},    int'(ProgCtr),     m_pc);
    check({tag, ".run"},   int'(Running),     int'(m_phase == PH_RUN));
    check({tag, ".done"},  int'(Done),        int'(m_phase == PH_HALT));
    check({tag, ".cnt"},   int'(CycleCount),  m_cnt16);
    check({tag, ".pc4"},   int'(ProgCtr4),    m_pc);
    check({tag, ".cnt4"},  int'(CycleCount4), m_cnt4);
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) cycle("reset");
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, i[0], i[1], 7, 1);
      cycle("idle");
    end
    check("idle_pc", int'(ProgCtr), 0);

    // straight-line run of program 1
    drive(1, 1, 0, 0, 0, 0); cycle("sl_start");
    check("sl_first_pc", int'(ProgCtr), 256);
    drive(0, 0, 0, 0, 0, 0); repeat (4) cycle("sl_step");
    drive(0, 0, 0, 0, 0, 1); cycle("sl_ack");
    drive(0, 0, 0, 0, 0, 0); cycle("sl_hold");
    check("sl_pc", int'(ProgCtr), 260);
    check("sl_done", int'(Done), 1);
    check("sl_cnt", int'(CycleCount), 5);

    // branches
    drive(1, 1, 0, 0, 0, 0); cycle("br_start");
    drive(0, 0, 0, 1, 44, 0); cycle("br_to300");
    drive(0, 0, 0, 1, 20, 0); cycle("br_down");
    check("br_320", int'(ProgCtr), 320);
    drive(0, 0, 1, 0, 25, 0); cycle("br_up");
    check("br_295", int'(ProgCtr), 295);
    drive(0, 0, 1, 1, 5, 0); cycle("br_both");
    check("br_300", int'(ProgCtr), 300);
    drive(0, 0, 1, 0, 0, 0); cycle("br_zero");
    check("br_loop", int'(ProgCtr), 300);

    // wrap-around
    drive(0, 0, 0, 1, 255, 0); repeat (2) cycle("wr_climb");
    drive(0, 0, 0, 1, 210, 0); cycle("wr_to1020");
    drive(0, 0, 0, 1, 10, 0);  cycle("wr_fwd");
    check("wr_6", int'(ProgCtr), 6);
    drive(0, 0, 1, 0, 3, 0);   cycle("wr_to3");
    drive(0, 0, 1, 0, 8, 0);   cycle("wr_back");
    check("wr_1019", int'(ProgCtr), 1019);
    drive(0, 0, 0, 1, 4, 0);   cycle("wr_to1023");
    drive(0, 0, 0, 0, 0, 0);   cycle("wr_inc");
    check("wr_0", int'(ProgCtr), 0);

    // Ack priority and restart from HALT
    drive(0, 0, 0, 1, 40, 0); cycle("ak_to40");
    drive(1, 2, 0, 1, 9, 1);  cycle("ak_both");
    check("ak_pc", int'(ProgCtr), 40);
    check("ak_done", int'(Done), 1);
    drive(1, 3, 0, 0, 0, 0);  cycle("ak_restart");
    check("rs_pc", int'(ProgCtr), 0);
    check("rs_done", int'(Done), 0);
    check("rs_run", int'(Running), 1);
    check("rs_cnt", int'(CycleCount), 0);

    // saturation of the 4-bit counter, then reset mid-run
    drive(0, 0, 0, 0, 0, 0); repeat (20) cycle("sat_run");
    check("sat4", int'(CycleCount4), 15);
    check("sat16", int'(CycleCount), 20);
    drive(0, 0, 0, 0, 0, 1); cycle("sat_ack");
    drive(1, 2, 0, 0, 0, 0); cycle("mr_start");
    drive(0, 0, 0, 0, 0, 0); repeat (5) cycle("mr_step");
    check("mr_517", int'(ProgCtr), 517);
    Reset = 1'b1; drive(1, 1, 0, 1, 3, 0); cycle("mr_reset");
    check("mr_pc", int'(ProgCtr), 0);
    check("mr_run", int'(Running), 0);
    Reset = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 3),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 255), $urandom_range(0, 39) == 0);
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
